// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: channel count, timing defaults, button indices.
package btn_pkg;

  localparam int unsigned N_BTN = 5;

  localparam int unsigned BTN_SELECT = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_UP     = 2;
  localparam int unsigned BTN_CLEAR  = 3;
  localparam int unsigned BTN_PLAY   = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;
  localparam logic [N_BTN-1:0] DEF_REPEAT_MASK = N_BTN'((1 << BTN_DOWN) | (1 << BTN_UP));

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw board inputs towards the conditioner, conditioned level/strobes back out.
interface button_conditioner_if #(
  parameter int unsigned Width = btn_pkg::N_BTN
) ();

  logic [Width-1:0] btn_raw;
  logic [Width-1:0] btn_level;
  logic [Width-1:0] btn_pulse;
  logic             pulse_any;

  modport master (output btn_raw, input btn_level, input btn_pulse, input pulse_any);
  modport slave  (input btn_raw, output btn_level, output btn_pulse, output pulse_any);

endinterface

// File: rtl/debounce_channel.sv
// One button: 2-flop synchronizer, debounce counter, level and press strobe.
// Auto-repeat hold counter is built only when BTN_AUTOREPEAT_EN is defined.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o,
  output logic pulse_next_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic s1_q, s1_d, s2_q, s2_d;
  logic level_q, level_d;
  logic pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic repeat_fire;

  always_comb begin
    s1_d    = raw_i;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = (level_d & ~level_q) | repeat_fire;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int unsigned HoldW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [HoldW-1:0] hold_q, hold_d, target;
    logic rep_q, rep_d, fire;

    // rep_q selects the first-repeat delay versus the steady repeat period.
    always_comb begin
      hold_d = hold_q;
      rep_d  = rep_q;
      fire   = 1'b0;
      target = rep_q ? HoldW'(REPEAT_PERIOD - 1) : HoldW'(REPEAT_DELAY - 1);
      if (!level_d || !level_q) begin
        hold_d = '0;
        rep_d  = 1'b0;
      end else if (hold_q == target) begin
        fire   = 1'b1;
        hold_d = '0;
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        hold_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        rep_q  <= rep_d;
      end
    end

    assign repeat_fire = fire;
  end else begin : g_norep
    assign repeat_fire = 1'b0;
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign level_o      = level_q;
  assign pulse_o      = pulse_q;
  assign pulse_next_o = pulse_d;

endmodule

// File: rtl/button_conditioner.sv
// Top: one debounce_channel per button plus the registered any-pulse flag.
// Optional auto-repeat on REPEAT_MASK channels is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned        N_BTN           = btn_pkg::N_BTN,
  parameter int unsigned        DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned        REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned        REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0]   REPEAT_MASK     = DEF_REPEAT_MASK
) (
  input logic clk,
  input logic rst_n,
  button_conditioner_if.slave bus
);

  logic [N_BTN-1:0] level, pulse, pulse_next;
  logic pulse_any_q, pulse_any_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .raw_i        (bus.btn_raw[i]),
      .level_o      (level[i]),
      .pulse_o      (pulse[i]),
      .pulse_next_o (pulse_next[i])
    );
  end

  // Built from next-cycle pulses so it lines up with btn_pulse.
  always_comb pulse_any_d = |pulse_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_any_q <= 1'b0;
    end else begin
      pulse_any_q <= pulse_any_d;
    end
  end

  assign bus.btn_level = level;
  assign bus.btn_pulse = pulse;
  assign bus.pulse_any = pulse_any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations plus random
// stimulus compared every cycle against a stability/time-based model of the button rules.
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int unsigned NB = 5;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 3;
  localparam logic [NB-1:0] MASK = 5'b00110;

  logic clk = 1'b0;
  logic rst_n;

  button_conditioner_if #(.Width(NB)) bus ();

  button_conditioner #(
    .N_BTN           (NB),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: s2 is raw delayed two edges; level flips at the D-th consecutive edge on which
  // s2 disagrees with it; repeats are timed from the press edge.
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_pulse;
  logic m_any;
  int since [NB];
  int press [NB];
  int ecnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      ecnt++;
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0;
        for (int i = 0; i < NB; i++) begin
          since[i] = -1;
          press[i] = -1;
        end
      end else begin
        for (int i = 0; i < NB; i++) begin
          logic old_lvl, p;
          old_lvl = m_lvl[i];
          p = 1'b0;
          if (m_s2[i] != m_lvl[i]) begin
            if (since[i] < 0) since[i] = ecnt;
            if (ecnt - since[i] + 1 == int'(D)) begin
              m_lvl[i] = m_s2[i];
              since[i] = -1;
              if (m_lvl[i]) begin
                p = 1'b1;
                press[i] = ecnt;
              end
            end
          end else begin
            since[i] = -1;
          end
`ifdef BTN_AUTOREPEAT_EN
          if (MASK[i] && old_lvl && m_lvl[i] && press[i] >= 0) begin
            int k;
            k = ecnt - press[i];
            if (k == int'(RD) || (k > int'(RD) && (k - int'(RD)) % int'(RP) == 0)) p = 1'b1;
          end
`endif
          m_pulse[i] = p;
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_raw;
      end
      m_any = |m_pulse;
      chk_en = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_level", 32'(bus.btn_level), 32'(m_lvl));
        chk("model_pulse", 32'(bus.btn_pulse), 32'(m_pulse));
        chk("model_pulse_any", 32'(bus.pulse_any), 32'(m_any));
      end
    end
  end

  initial begin
    logic [NB-1:0] seen_p, seen_l;
    logic [20:0] got_mask;
    int npulse;

    rst_n = 1'b0;
    bus.btn_raw = 5'b11111;
    repeat (3) begin
      tick(1);
      chk("rst_level", 32'(bus.btn_level), 0);
      chk("rst_pulse", 32'(bus.btn_pulse), 0);
      chk("rst_pulse_any", 32'(bus.pulse_any), 0);
    end
    bus.btn_raw = '0;
    rst_n = 1'b1;
    tick(8);

    // Single press on SELECT: accepted on edge 6, strobe one cycle, no strobe on release.
    bus.btn_raw[BTN_SELECT] = 1'b1;
    tick(5);
    chk("sel_edge5_level", 32'(bus.btn_level[BTN_SELECT]), 0);
    tick(1);
    chk("sel_edge6_level", 32'(bus.btn_level[BTN_SELECT]), 1);
    chk("sel_edge6_pulse", 32'(bus.btn_pulse), 32'h01);
    chk("sel_edge6_any", 32'(bus.pulse_any), 1);
    tick(1);
    chk("sel_edge7_pulse", 32'(bus.btn_pulse), 0);
    chk("sel_edge7_level", 32'(bus.btn_level[BTN_SELECT]), 1);
    bus.btn_raw[BTN_SELECT] = 1'b0;
    seen_p = '0;
    repeat (10) begin
      tick(1);
      seen_p |= bus.btn_pulse;
    end
    chk("sel_release_nopulse", 32'(seen_p), 0);
    chk("sel_release_level", 32'(bus.btn_level), 0);

    // Three-cycle glitch on CLEAR is rejected.
    seen_p = '0; seen_l = '0;
    bus.btn_raw[BTN_CLEAR] = 1'b1;
    repeat (3) begin
      tick(1);
      seen_p |= bus.btn_pulse; seen_l |= bus.btn_level;
    end
    bus.btn_raw[BTN_CLEAR] = 1'b0;
    repeat (8) begin
      tick(1);
      seen_p |= bus.btn_pulse; seen_l |= bus.btn_level;
    end
    chk("glitch_level", 32'(seen_l[BTN_CLEAR]), 0);
    chk("glitch_pulse", 32'(seen_p[BTN_CLEAR]), 0);

    // Simultaneous DOWN + PLAY.
    bus.btn_raw = 5'b10010;
    tick(6);
    chk("dual_pulse", 32'(bus.btn_pulse), 32'h12);
    chk("dual_any", 32'(bus.pulse_any), 1);
    tick(1);
    chk("dual_pulse_after", 32'(bus.btn_pulse), 0);
    chk("dual_any_after", 32'(bus.pulse_any), 0);
    bus.btn_raw = '0;
    tick(10);

    // UP held 20 cycles past its press strobe: repeat map depends on configuration.
    bus.btn_raw[BTN_UP] = 1'b1;
    tick(6);
    chk("up_press_pulse", 32'(bus.btn_pulse[BTN_UP]), 1);
    got_mask = '0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (bus.btn_pulse[BTN_UP]) got_mask[k] = 1'b1;
    end
`ifdef BTN_AUTOREPEAT_EN
    chk("up_repeat_map", 32'(got_mask), 32'h124900);
`else
    chk("up_repeat_map", 32'(got_mask), 0);
`endif
    bus.btn_raw[BTN_UP] = 1'b0;
    tick(10);

    // SELECT held identically is not repeat-eligible.
    bus.btn_raw[BTN_SELECT] = 1'b1;
    npulse = 0;
    repeat (26) begin
      tick(1);
      if (bus.btn_pulse[BTN_SELECT]) npulse++;
    end
    chk("sel_hold_single_pulse", 32'(npulse), 1);
    bus.btn_raw[BTN_SELECT] = 1'b0;
    tick(10);

    // Reset mid-count on PLAY: partial count discarded, fresh press after reset.
    bus.btn_raw[BTN_PLAY] = 1'b1;
    tick(2);
    rst_n = 1'b0;
    seen_p = '0;
    tick(2);
    seen_p |= bus.btn_pulse;
    rst_n = 1'b1;
    repeat (5) begin
      tick(1);
      seen_p |= bus.btn_pulse;
    end
    chk("play_no_early_pulse", 32'(seen_p[BTN_PLAY]), 0);
    tick(1);
    chk("play_pulse_after_reset", 32'(bus.btn_pulse[BTN_PLAY]), 1);
    bus.btn_raw[BTN_PLAY] = 1'b0;
    tick(10);

    // Random phase: bursts of varying stability, occasional reset.
    begin
      int unsigned odds;
      odds = 8;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        if (cyc % 250 == 0) begin
          case ($urandom_range(0, 2))
            0: odds = 1;
            1: odds = 6;
            default: odds = 40;
          endcase
        end
        for (int i = 0; i < int'(NB); i++) begin
          if ($urandom_range(0, odds) == 0) bus.btn_raw[i] = ~bus.btn_raw[i];
        end
        rst_n = ($urandom_range(0, 599) != 0);
        tick(1);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 5: number of button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: cycles a changed input must stay stable before it is accepted (10 ms at 100 MHz); legal range >= 2.
REQ-003 Parameter REPEAT_DELAY, default 50000000: held cycles before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 10000000: cycles between later auto-repeat pulses.
REQ-005 Parameter REPEAT_MASK, default 5'b00110: channels eligible for auto-repeat (pitch down/up).
REQ-006 clk  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 btn_raw  input  N_BTN  asynchronous active-high board buttons.
REQ-009 btn_level  output  N_BTN  debounced, registered button state.
REQ-010 btn_pulse  output  N_BTN  single-cycle press strobes, consumed by the sequencer control FSM.
REQ-011 pulse_any  output  1  registered OR-reduction of the next-cycle btn_pulse value; asserts in the same cycle as btn_pulse.

Function
REQ-012 Each channel passes btn_raw through its own 2-flop synchronizer (s1, s2) before any other use.
REQ-013 Each channel holds a counter that increments while s2 != btn_level and clears to 0 on any cycle where s2 == btn_level.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and s2 != btn_level, the next edge loads btn_level <= s2 and clears the counter.
REQ-015 Latency: after a raw change held stable, btn_level changes on the (DEBOUNCE_CYCLES+2)th rising edge after the change, counting the first sampling edge as edge 1.
REQ-016 A disagreement lasting fewer than DEBOUNCE_CYCLES consecutive s2 cycles produces no change on btn_level or btn_pulse.
REQ-017 btn_pulse[i] is high for exactly one cycle, in the same cycle btn_level[i] first reads 1; a release produces no pulse.
REQ-018 Channels are fully independent; simultaneous presses produce simultaneous pulses, and no priority is applied in this block.
REQ-019 Counter width is $clog2(DEBOUNCE_CYCLES); the counter never wraps, because it is bounded by REQ-014.

Configuration
REQ-020 With macro BTN_AUTOREPEAT_EN defined, each channel set in REPEAT_MASK has a hold counter that starts at the press pulse.
REQ-021 With BTN_AUTOREPEAT_EN, the channel emits an extra one-cycle btn_pulse REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles while btn_level stays 1.
REQ-022 With BTN_AUTOREPEAT_EN, the hold counter clears when btn_level falls; no repeat pulse is emitted in or after the release cycle.
REQ-023 Without BTN_AUTOREPEAT_EN, no hold-counter logic is synthesized; REPEAT_* parameters are accepted but ignored, and each press yields exactly one pulse.

Reset
REQ-024 While rst_n == 0 at an edge, the following clear to 0: s1, s2, btn_level, btn_pulse, pulse_any, all debounce counters and all hold counters.
REQ-025 Reset asserted mid-press or mid-count discards the partial count; after release, a still-held button is treated as a new press (pulse after DEBOUNCE_CYCLES+2 edges).
REQ-026 Reset is sampled only on clk edges; no asynchronous path from rst_n to any flop.

Structure
REQ-027 Package btn_pkg holds: N_BTN; the default DEBOUNCE/REPEAT constants; and button index constants BTN_SELECT=0, BTN_DOWN=1, BTN_UP=2, BTN_CLEAR=3, BTN_PLAY=4.
REQ-028 Sub-module debounce_channel (synchronizer, debounce counter, level, pulse, optional repeat) is instantiated N_BTN times in a generate loop; the top contains only the loop and pulse_any.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-029 rst_n=0 with btn_raw=5'b11111 for 3 cycles -> btn_level=0, btn_pulse=0, pulse_any=0 throughout.
REQ-030 btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_pulse[0]=1 on edge 6, btn_pulse[0]=0 on edge 7; release gives no pulse.
REQ-031 btn_raw[3] high for 3 cycles, then low -> btn_level[3] and btn_pulse[3] stay 0.
REQ-032 btn_raw[1] and btn_raw[4] rise together -> btn_pulse=5'b10010 for one cycle, pulse_any=1 that cycle only.
REQ-033 BTN_AUTOREPEAT_EN defined, btn_raw[2] held 20 cycles after its press pulse -> pulses at press+0, +8, +11, +14, +17, +20; btn_raw[0] held identically -> a single pulse.
REQ-034 rst_n pulsed low 2 cycles after btn_raw[4] rises, button still held -> no pulse before reset; one pulse 6 edges after rst_n returns high.
